mw93_master: RTL and testbench

// - Microwire (93xx serial EEPROM) master. Turns single bus commands (READ/WRITE/ERASE/EWEN) into
//   CS/SK/DI frames and shifts the DO response back in.
// - Initiator for the 93xx slave-side decode logic. Sits between the host bus register file and the EEPROM pins.

---
 rtl/mw93_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_mw93_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mw93_master.sv
// rtl/mw93_master.sv - Microwire (93xx EEPROM) command master; optional poll timeout via MW_POLL_TIMEOUT_EN
`timescale 1ns/1ps
module mw93_master #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int POLL_TO = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              mw_cs,
    output logic              mw_sk,
    output logic              mw_di,
    input  logic              mw_do
);

    localparam int HDR_W = 3 + ADDR_W;
    localparam int FRM_W = HDR_W + DATA_W;
    localparam int BIT_W = $clog2(FRM_W);
    localparam int CNT_W = $clog2(2 * CLK_DIV);

    localparam logic [BIT_W-1:0]  HDR_LAST  = BIT_W'(HDR_W - 1);
    localparam logic [BIT_W-1:0]  FRM_LAST  = BIT_W'(FRM_W - 1);
    localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CELL_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [ADDR_W-1:0] EWEN_ADDR = {2'b11, {(ADDR_W-2){1'b0}}};

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;

    // Illegal divider or timeout values cannot produce a valid SK waveform
    if (CLK_DIV < 3 || POLL_TO < 1) begin : g_bad_params
        $error("mw93_master: CLK_DIV must be >= 3 and POLL_TO >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SHIFT, S_RDIN, S_GAP, S_POLL, S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        op;
    logic [FRM_W-1:0]  sh;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] rd_next;
    logic [CNT_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              do_meta;
    logic              do_sync;
    logic [1:0]        hdr_op;
    logic [ADDR_W-1:0] hdr_addr;
    logic [DATA_W-1:0] hdr_data;
    logic              err_q;

`ifdef MW_POLL_TIMEOUT_EN
    localparam int PW = $clog2(POLL_TO + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TO - 1);
    logic [PW-1:0] poll_cnt;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign busy    = ~cmd_ready;
    assign rd_next = {rd_sh[DATA_W-2:0], do_sync};

    // Translate the bus opcode into the on-wire opcode/address/data fields
    always_comb begin
        hdr_op   = 2'b10;
        hdr_addr = cmd_addr;
        hdr_data = '0;
        case (cmd_op)
            OP_READ:  hdr_op = 2'b10;
            OP_WRITE: begin
                hdr_op   = 2'b01;
                hdr_data = cmd_wdata;
            end
            OP_ERASE: hdr_op = 2'b11;
            default: begin
                hdr_op   = 2'b00;
                hdr_addr = EWEN_ADDR;
            end
        endcase
    end

    // Two-flop synchroniser for the asynchronous EEPROM data output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            do_meta <= 1'b0;
            do_sync <= 1'b0;
        end else begin
            do_meta <= mw_do;
            do_sync <= do_meta;
        end
    end

    // Frame sequencer: all pin and response outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op        <= OP_READ;
            sh        <= '0;
            rd_sh     <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            err_q     <= 1'b0;
            mw_cs     <= 1'b0;
            mw_sk     <= 1'b0;
            mw_di     <= 1'b0;
`ifdef MW_POLL_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            err_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op        <= cmd_op;
                        sh        <= {1'b1, hdr_op, hdr_addr, hdr_data};
                        bit_cnt   <= '0;
                        div_cnt   <= '0;
                        mw_cs     <= 1'b1;
                        mw_sk     <= 1'b0;
                        mw_di     <= 1'b0;
                        cmd_ready <= 1'b0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    if (div_cnt == LOW_LAST) begin
                        div_cnt <= '0;
                        mw_di   <= sh[FRM_W-1];
                        state   <= S_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt == LOW_LAST) begin
                        mw_sk <= 1'b1;
                    end
                    if (div_cnt == CELL_LAST) begin
                        mw_sk   <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        sh      <= sh << 1;
                        if (bit_cnt == ((op == OP_WRITE) ? FRM_LAST : HDR_LAST)) begin
                            mw_di <= 1'b0;
                            case (op)
                                OP_READ:  state <= S_RDIN;
                                OP_WRITE, OP_ERASE: begin
                                    mw_cs <= 1'b0;
                                    state <= S_GAP;
                                end
                                default: begin
                                    mw_cs     <= 1'b0;
                                    rsp_valid <= 1'b1;
                                    state     <= S_DONE;
                                end
                            endcase
                        end else begin
                            mw_di <= sh[FRM_W-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_RDIN: begin
                    if (div_cnt == LOW_LAST) begin
                        mw_sk <= 1'b1;
                    end
                    if (div_cnt == CELL_LAST) begin
                        mw_sk   <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        rd_sh   <= rd_next;
                        if (bit_cnt == FRM_LAST) begin
                            mw_cs     <= 1'b0;
                            rsp_rdata <= rd_next;
                            rsp_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (div_cnt == LOW_LAST) begin
                        div_cnt  <= '0;
                        mw_cs    <= 1'b1;
                        state    <= S_POLL;
`ifdef MW_POLL_TIMEOUT_EN
                        poll_cnt <= '0;
`endif
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_POLL: begin
                    if (do_sync) begin
                        mw_cs     <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_DONE;
                    end
`ifdef MW_POLL_TIMEOUT_EN
                    else if (poll_cnt == POLL_LAST) begin
                        mw_cs     <= 1'b0;
                        rsp_valid <= 1'b1;
                        err_q     <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    mw_cs     <= 1'b0;
                    mw_sk     <= 1'b0;
                    mw_di     <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mw93_master.sv
// tb/tb_mw93_master.sv - self-checking bench for mw93_master with a behavioural 93C46 model
`timescale 1ns/1ps
module tb_mw93_master;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 16;
    localparam int CLK_DIV = 4;
    localparam int POLL_TO = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              mw_cs;
    logic              mw_sk;
    logic              mw_di;
    logic              mw_do = 1'b0;

    always #5 clk = ~clk;

    mw93_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .POLL_TO(POLL_TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .mw_cs(mw_cs), .mw_sk(mw_sk), .mw_di(mw_di), .mw_do(mw_do)
    );

    int vectors = 0;
    int miscompares = 0;

    // EEPROM model state
    logic [15:0] eep_mem [64];
    logic [15:0] ref_mem [64];
    logic [31:0] rx = '0;
    logic [31:0] last_frame = '0;
    logic [15:0] rd_word = '0;
    logic [1:0]  frame_op = 2'b00;
    logic        prev_sk = 1'b0;
    logic        prev_cs = 1'b0;
    int n_rx = 0, last_n = 0, busy_left = -1, busy_cfg = 50, cyc = 0;
    int do_rise_cyc = 0, cs_rise_cyc = 0, cs_low_run = 0, last_low_run = 0;
    int rsp_count = 0, sk_viol = 0;
    logic [15:0] exp_rdata = '0;

    // Behavioural 93C46: decodes frames from SK rising edges, answers READs, busy after WRITE/ERASE
    always @(negedge clk) begin
        cyc++;
        if (mw_sk && !mw_cs) sk_viol++;
        if (rsp_valid) rsp_count++;
        if (!rst_n) begin
            n_rx = 0; rx = '0; mw_do = 1'b0; busy_left = -1;
            prev_sk = 1'b0; prev_cs = 1'b0; cs_low_run = 0;
        end else begin
            if (mw_cs && mw_sk && !prev_sk) begin
                rx = {rx[30:0], mw_di};
                n_rx++;
                if (n_rx == 3) frame_op = rx[1:0];
                if (frame_op == 2'b10 && n_rx == 9) begin
                    rd_word = eep_mem[rx[5:0]];
                    mw_do = 1'b0;
                end else if (frame_op == 2'b10 && n_rx > 9 && n_rx <= 25) begin
                    mw_do = rd_word[25-n_rx];
                end
            end
            if (mw_cs && !prev_cs) begin
                last_low_run = cs_low_run;
                cs_rise_cyc = cyc;
            end
            if (!mw_cs && prev_cs) begin
                if (n_rx > 0) begin
                    last_frame = rx;
                    last_n = n_rx;
                    if (frame_op == 2'b01 && n_rx == 25) begin
                        eep_mem[rx[21:16]] = rx[15:0];
                        busy_left = busy_cfg;
                    end else if (frame_op == 2'b11 && n_rx == 9) begin
                        eep_mem[rx[5:0]] = 16'hFFFF;
                        busy_left = busy_cfg;
                    end
                end
                mw_do = 1'b0; n_rx = 0; rx = '0;
            end
            cs_low_run = mw_cs ? 0 : cs_low_run + 1;
            if (busy_left > 0) busy_left--;
            else if (busy_left == 0) begin
                mw_do = 1'b1; do_rise_cyc = cyc; busy_left = -1;
            end
            prev_sk = mw_sk;
            prev_cs = mw_cs;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_frame(input logic [1:0] op, input logic [5:0] a, input logic [15:0] d);
        case (op)
            2'b00:   return {7'b0, 1'b1, 2'b10, a, 16'h0000};
            2'b01:   return {7'b0, 1'b1, 2'b01, a, d};
            2'b10:   return {23'b0, 1'b1, 2'b11, a};
            default: return {23'b0, 9'b100110000};
        endcase
    endfunction

    task automatic wait_rsp(input int budget, output bit got, output int rc);
        got = 1'b0;
        rc = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) begin got = 1'b1; rc = cyc; end
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] a, input logic [15:0] d,
                           output bit got, output int rc);
        @(negedge clk);
        cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_addr = 6'($urandom); cmd_wdata = 16'($urandom);
        wait_rsp(3000, got, rc);
    endtask

    task automatic do_and_check(input logic [1:0] op, input logic [5:0] a, input logic [15:0] d, input int bz);
        bit got;
        int rc;
        busy_cfg = bz;
        run_cmd(op, a, d, got, rc);
        check("rsp_seen", 32'(got), 32'd1);
        if (op == 2'b00) exp_rdata = ref_mem[a];
        if (op == 2'b01) ref_mem[a] = d;
        if (op == 2'b10) ref_mem[a] = 16'hFFFF;
        check("frame_bits", last_frame, exp_frame(op, a, d));
        check("sk_pulses", 32'(last_n), (op == 2'b00 || op == 2'b01) ? 32'd25 : 32'd9);
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        check("rsp_err", 32'(rsp_err), 32'd0);
        if (op == 2'b01 || op == 2'b10) begin
            check("gap_cs_low", 32'(last_low_run), 32'(CLK_DIV));
            check("poll_latency", 32'(rc - do_rise_cyc), 32'd3);
        end
        @(negedge clk); #1;
        check("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        check("ready_after_done", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        bit got;
        int rc, rc0;
        logic [5:0] a1, a2;
        for (int i = 0; i < 64; i++) begin
            eep_mem[i] = 16'($urandom);
            ref_mem[i] = eep_mem[i];
        end
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs", 32'(mw_cs), 32'd0);
        check("rst_sk", 32'(mw_sk), 32'd0);
        check("rst_di", 32'(mw_di), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Directed READ, WRITE, EWEN
        eep_mem[6'h15] = 16'hA5C3;
        ref_mem[6'h15] = 16'hA5C3;
        do_and_check(2'b00, 6'h15, 16'h0000, 0);
        check("read_a5c3", 32'(rsp_rdata), 32'hA5C3);
        do_and_check(2'b01, 6'h3F, 16'h1234, 200);
        do_and_check(2'b11, 6'h00, 16'h0000, 0);
        do_and_check(2'b00, 6'h3F, 16'h0000, 0);

        // Back-to-back READ then ERASE with cmd_valid held high
        a1 = 6'($urandom); a2 = a1 ^ 6'h21;
        busy_cfg = 30;
        @(negedge clk);
        cmd_op = 2'b00; cmd_addr = a1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_op = 2'b10; cmd_addr = a2;
        wait_rsp(3000, got, rc);
        check("b2b_read_seen", 32'(got), 32'd1);
        exp_rdata = ref_mem[a1];
        check("b2b_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        @(negedge clk); #1;
        check("b2b_idle_ready", 32'(cmd_ready), 32'd1);
        check("b2b_idle_cs", 32'(mw_cs), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk); #1;
        check("b2b_start_cs", 32'(mw_cs), 32'd1);
        check("b2b_start_ready", 32'(cmd_ready), 32'd0);
        check("b2b_cs_low", 32'(last_low_run), 32'd2);
        wait_rsp(3000, got, rc);
        check("b2b_erase_seen", 32'(got), 32'd1);
        ref_mem[a2] = 16'hFFFF;
        check("b2b_erase_frame", last_frame, exp_frame(2'b10, a2, 16'h0));
        do_and_check(2'b00, a2, 16'h0000, 0);

        // Asynchronous reset in the middle of a READ
        @(negedge clk);
        cmd_op = 2'b00; cmd_addr = 6'h0A; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk); #1;
            if (n_rx == 12) got = 1'b1;
        end
        check("reached_sk12", 32'(got), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs", 32'(mw_cs), 32'd0);
        check("arst_sk", 32'(mw_sk), 32'd0);
        check("arst_di", 32'(mw_di), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        rc0 = rsp_count;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_no_rsp", 32'(rsp_count), 32'(rc0));
        exp_rdata = '0;
        check("arst_rdata", 32'(rsp_rdata), 32'd0);
        do_and_check(2'b00, 6'h0A, 16'h0000, 0);

        // Randomised traffic against the reference memory
        for (int k = 0; k < 8; k++) begin
            do_and_check(2'($urandom_range(0, 2)), 6'($urandom), 16'($urandom), $urandom_range(10, 200));
        end
        for (int k = 0; k < 3; k++) begin
            do_and_check(2'b00, 6'($urandom), 16'h0000, 0);
        end

`ifdef MW_POLL_TIMEOUT_EN
        // EEPROM never becomes ready after ERASE
        busy_cfg = -1;
        a1 = 6'($urandom);
        run_cmd(2'b10, a1, 16'h0000, got, rc);
        ref_mem[a1] = 16'hFFFF;
        check("to_seen", 32'(got), 32'd1);
        check("to_err", 32'(rsp_err), 32'd1);
        check("to_latency", 32'(rc - cs_rise_cyc), 32'(POLL_TO));
        @(negedge clk); #1;
        check("to_ready", 32'(cmd_ready), 32'd1);
        do_and_check(2'b11, 6'h00, 16'h0000, 0);
`endif

        check("sk_high_cs_low", 32'(sk_viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
